mul_div_unit: RTL and testbench

Iterative unsigned multiply/divide unit for the CPU datapath. Consumes the two register-file read operands (rs1/rs2 data) and the destination index, computes one of MUL/MULHU/DIVU/REMU over multiple cycles, then drives a one-cycle write request (rd/wd/we) that connects directly to the register file write port. Sits between the register-file read stage and the register-file write port, beside the single-cycle ALU.

---
 rtl/mul_div_unit.sv | 180 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mul_div_unit
//  Purpose  : Iterative unsigned MUL/MULHU/DIVU/REMU unit with a one-cycle
//             register-file write request. Define MDU_EARLY_OUT_EN to let
//             multiplies finish as soon as the remaining multiplier is zero.
//  Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [4:0]      rd_in,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] wd,
    output logic            we
);

    localparam int c_cnt_w = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic                  r_upper;      // MULHU / REMU select the second result
    logic [4:0]            r_rd_tgt;
    logic [2*XLEN-1:0]     r_a;          // zero-extended multiplicand, shifted left
    logic [XLEN-1:0]       r_b;          // multiplier (shifted) or divisor (static)
    logic [2*XLEN-1:0]     r_acc;
    logic [XLEN-1:0]       r_dvd;        // dividend shifting out, quotient shifting in
    logic [XLEN-1:0]       r_rem;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [4:0]            r_rd;
    logic [XLEN-1:0]       r_wd;

    logic [2*XLEN-1:0]     w_acc_next;
    logic [XLEN-1:0]       w_b_next;
    logic                  w_last_iter;
    logic                  w_mul_done;
    logic                  w_div_zero;
    logic [XLEN:0]         w_rem_sh;
    logic [XLEN:0]         w_diff;
    logic                  w_ge;
    logic [XLEN-1:0]       w_rem_next;
    logic [XLEN-1:0]       w_dvd_next;

    assign w_acc_next  = r_b[0] ? (r_acc + r_a) : r_acc;
    assign w_b_next    = r_b >> 1;
    assign w_last_iter = (r_cnt == c_cnt_w'(XLEN - 1));
`ifdef MDU_EARLY_OUT_EN
    assign w_mul_done  = w_last_iter || (w_b_next == '0);
`else
    assign w_mul_done  = w_last_iter;
`endif
    assign w_div_zero  = (r_b == '0);

    // The shifted partial remainder needs one extra bit when the divisor is
    // above 2^(XLEN-1), otherwise its top bit would be lost before comparing.
    assign w_rem_sh    = {r_rem, r_dvd[XLEN-1]};
    assign w_diff      = w_rem_sh - {1'b0, r_b};
    assign w_ge        = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_next  = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    assign w_dvd_next  = {r_dvd[XLEN-2:0], w_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_next = op[1] ? S_DIV : S_MUL;
                    end
                end
                S_MUL: begin
                    if (w_mul_done) begin
                        w_state_next = S_WB;
                    end
                end
                S_DIV: begin
                    if (w_div_zero || w_last_iter) begin
                        w_state_next = S_WB;
                    end
                end
                S_WB: begin
                    w_state_next = S_IDLE;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upper  <= 1'b0;
            r_rd_tgt <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_dvd    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_rd     <= '0;
            r_wd     <= '0;
        end else if (!flush) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_upper  <= op[0];
                        r_rd_tgt <= rd_in;
                        r_a      <= {{XLEN{1'b0}}, a};
                        r_b      <= b;
                        r_acc    <= '0;
                        r_dvd    <= a;
                        r_rem    <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_MUL: begin
                    r_acc <= w_acc_next;
                    r_a   <= r_a << 1;
                    r_b   <= w_b_next;
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    if (w_mul_done) begin
                        r_rd <= r_rd_tgt;
                        r_wd <= r_upper ? w_acc_next[2*XLEN-1:XLEN] : w_acc_next[XLEN-1:0];
                    end
                end
                S_DIV: begin
                    if (w_div_zero) begin
                        r_rd <= r_rd_tgt;
                        r_wd <= r_upper ? r_dvd : {XLEN{1'b1}};
                    end else begin
                        r_rem <= w_rem_next;
                        r_dvd <= w_dvd_next;
                        r_cnt <= r_cnt + c_cnt_w'(1);
                        if (w_last_iter) begin
                            r_rd <= r_rd_tgt;
                            r_wd <= r_upper ? w_rem_next : w_dvd_next;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // A flush arriving during WB suppresses the write as well.
    assign we   = (r_state == S_WB) && (r_rd != 5'd0) && !flush;
    assign busy = (r_state != S_IDLE);
    assign rd   = r_rd;
    assign wd   = r_wd;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_div_unit
//  Purpose  : Self-checking bench for mul_div_unit: arithmetic reference model
//             compared every cycle, plus directed literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [4:0]  rd_in = 5'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        we;

    int checks = 0;
    int failures = 0;

`ifdef MDU_EARLY_OUT_EN
    localparam int WB_MUL76 = 3;
`else
    localparam int WB_MUL76 = 32;
`endif

    mul_div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .rd_in (rd_in),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .rd    (rd),
        .wd    (wd),
        .we    (we)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
        logic [63:0] p;
        p = {32'd0, x} * {32'd0, y};
        case (o)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (y == 0) ? 32'hFFFF_FFFF : x / y;
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    // Edges from accept to WB entry.
    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] y);
        if (o[1]) return (y == 0) ? 1 : 32;
`ifdef MDU_EARLY_OUT_EN
        for (int i = 31; i >= 0; i--) begin
            if (y[i]) return i + 1;
        end
        return 1;
`else
        return 32;
`endif
    endfunction

    // Transaction-level model: countdown to WB, result from plain arithmetic.
    logic        m_busy = 1'b0;
    logic        m_wb = 1'b0;
    int          m_left = 0;
    logic [31:0] m_res = 32'd0;
    logic [31:0] m_wd = 32'd0;
    logic [4:0]  m_rdt = 5'd0;
    logic [4:0]  m_rd = 5'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_wb   <= 1'b0;
            m_left <= 0;
            m_res  <= 32'd0;
            m_wd   <= 32'd0;
            m_rdt  <= 5'd0;
            m_rd   <= 5'd0;
        end else if (flush) begin
            m_busy <= 1'b0;
            m_wb   <= 1'b0;
            m_left <= 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1'b1;
                m_left <= ref_lat(op, b);
                m_res  <= ref_res(op, a, b);
                m_rdt  <= rd_in;
            end
        end else if (m_wb) begin
            m_busy <= 1'b0;
            m_wb   <= 1'b0;
        end else begin
            if (m_left == 1) begin
                m_wb <= 1'b1;
                m_rd <= m_rdt;
                m_wd <= m_res;
            end
            m_left <= m_left - 1;
        end
    end

    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("we", {31'd0, we}, {31'd0, (m_wb && (m_rd != 5'd0) && !flush)});
        chk("rd", {27'd0, rd}, {27'd0, m_rd});
        chk("wd", wd, m_wd);
    end

    // Starts one operation from an idle cycle and follows it to completion.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] r, input int poke_at, input int flush_at,
                          output logic [31:0] got_wd, output logic [4:0] got_rd,
                          output int wb_edge, output int we_n, output int busy_end);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 100 && busy; k++) begin
            @(posedge clk); #1;
        end
        start = 1'b1; op = o; a = x; b = y; rd_in = r;
        @(posedge clk); #1;
        start = 1'b0;
        got_wd = 32'd0; got_rd = 5'd0; wb_edge = -1; we_n = 0; busy_end = -1;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk); #1;
            if (we) begin
                we_n++;
                got_wd = wd;
                got_rd = rd;
                if (wb_edge < 0) wb_edge = n;
            end
            if (!busy) begin
                busy_end = n;
                done = 1'b1;
                break;
            end
            if (n == poke_at) begin
                start = 1'b1; op = 2'b11; a = 32'hDEAD_BEEF; b = 32'd1; rd_in = 5'd3;
            end
            if (n == poke_at + 2) start = 1'b0;
            if (n == flush_at) flush = 1'b1;
            if (n == flush_at + 1) flush = 1'b0;
        end
        start = 1'b0;
        flush = 1'b0;
        if (!done) chk("op_timeout", 32'd0, 32'd1);
    endtask

    logic [31:0] g_wd;
    logic [4:0]  g_rd;
    int          g_wb, g_we, g_end, ref_end;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_rd", {27'd0, rd}, 32'd0);
        chk("rst_wd", wd, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(2'd0, 32'd7, 32'd6, 5'd5, 0, 0, g_wd, g_rd, g_wb, g_we, g_end);
        chk("mul76_wd", g_wd, 32'd42);
        chk("mul76_rd", {27'd0, g_rd}, 32'd5);
        chk("mul76_we_count", g_we, 32'd1);
        chk("mul76_wb_edge", g_wb, WB_MUL76);
        chk("mul76_busy_end", g_end, WB_MUL76 + 1);

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0, 0, g_wd, g_rd, g_wb, g_we, g_end);
        chk("mulhu_max", g_wd, 32'hFFFF_FFFE);
        chk("mulhu_max_wb_edge", g_wb, 32'd32);
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0, 0, g_wd, g_rd, g_wb, g_we, g_end);
        chk("mul_max", g_wd, 32'h0000_0001);

        run_op(2'd2, 32'd100, 32'd7, 5'd6, 0, 0, g_wd, g_rd, g_wb, g_we, g_end);
        chk("divu_100_7", g_wd, 32'd14);
        chk("divu_wb_edge", g_wb, 32'd32);
        run_op(2'd3, 32'd100, 32'd7, 5'd6, 0, 0, g_wd, g_rd, g_wb, g_we, g_end);
        chk("remu_100_7", g_wd, 32'd2);
        run_op(2'd2, 32'd9, 32'd0, 5'd7, 0, 0, g_wd, g_rd, g_wb, g_we, g_end);
        chk("divu_by0", g_wd, 32'hFFFF_FFFF);
        chk("divu_by0_wb_edge", g_wb, 32'd1);
        run_op(2'd3, 32'd9, 32'd0, 5'd7, 0, 0, g_wd, g_rd, g_wb, g_we, g_end);
        chk("remu_by0", g_wd, 32'd9);

        run_op(2'd0, 32'd3, 32'd3, 5'd4, 0, 0, g_wd, g_rd, g_wb, g_we, ref_end);
        chk("mul33_wd", g_wd, 32'd9);
        run_op(2'd0, 32'd3, 32'd3, 5'd0, 0, 0, g_wd, g_rd, g_wb, g_we, g_end);
        chk("rd0_we_count", g_we, 32'd0);
        chk("rd0_busy_end", g_end, ref_end);

        run_op(2'd0, 32'd1234, 32'd5678, 5'd9, 5, 0, g_wd, g_rd, g_wb, g_we, g_end);
        chk("poke_wd", g_wd, 32'd7006652);
        chk("poke_rd", {27'd0, g_rd}, 32'd9);
        chk("poke_we_count", g_we, 32'd1);

        run_op(2'd2, 32'd1000000, 32'd3, 5'd12, 0, 9, g_wd, g_rd, g_wb, g_we, g_end);
        chk("flush_busy_end", g_end, 32'd10);
        chk("flush_we_count", g_we, 32'd0);
        run_op(2'd2, 32'd1000, 32'd33, 5'd12, 0, 0, g_wd, g_rd, g_wb, g_we, g_end);
        chk("after_flush_divu", g_wd, 32'd30);
        run_op(2'd3, 32'd1000, 32'd33, 5'd12, 0, 0, g_wd, g_rd, g_wb, g_we, g_end);
        chk("after_flush_remu", g_wd, 32'd10);

        start = 1'b1; op = 2'd0; a = 32'd100; b = 32'd200; rd_in = 5'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_we", {31'd0, we}, 32'd0);
        chk("async_rst_rd", {27'd0, rd}, 32'd0);
        chk("async_rst_wd", wd, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(2'd1, 32'h8000_0000, 32'd6, 5'd17, 0, 0, g_wd, g_rd, g_wb, g_we, g_end);
        chk("post_rst_mulhu", g_wd, 32'd3);
        chk("post_rst_rd", {27'd0, g_rd}, 32'd17);

        for (int i = 0; i < 6000; i++) begin
            @(posedge clk); #1;
            start = ($urandom_range(3) == 0);
            op    = 2'($urandom_range(3));
            a     = ($urandom_range(3) == 0) ? 32'($urandom_range(1000)) : $urandom;
            case ($urandom_range(7))
                0:       b = 32'd0;
                1, 2:    b = 32'($urandom_range(255));
                3:       b = 32'd1 << $urandom_range(31);
                default: b = $urandom;
            endcase
            rd_in = 5'($urandom_range(31));
            flush = ($urandom_range(99) == 0);
        end
        start = 1'b0;
        flush = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
